// File: rtl/pin_entry_if.sv
// Bus between the PIN-entry block and its surroundings.
// Carries the raw button/slow-clock inputs and the entry outputs.
interface pin_entry_if;
    logic        clk_slow;
    logic        btn_up;
    logic        btn_down;
    logic        btn_enter;
    logic        btn_clear;
    logic [15:0] pin_out;
    logic [3:0]  cur_digit;
    logic [1:0]  digit_idx;
    logic        busy;
    logic        pin_valid;

    modport master (
        output clk_slow, btn_up, btn_down, btn_enter, btn_clear,
        input  pin_out, cur_digit, digit_idx, busy, pin_valid
    );

    modport slave (
        input  clk_slow, btn_up, btn_down, btn_enter, btn_clear,
        output pin_out, cur_digit, digit_idx, busy, pin_valid
    );
endinterface

// File: rtl/pin_entry.sv
// Four-digit BCD PIN entry: synchronized, debounced buttons drive an
// IDLE/ENTRY/DONE state machine that dials and stores digits.
module pin_entry #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pin_entry_if.slave  bus
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    // Bit order: 0 up, 1 down, 2 enter, 3 clear, 4 slow clock.
    logic [4:0]      raw;
    logic [4:0]      sync1_q, sync2_q;
    logic            slow_prev_q;
    logic            tick;
    logic [3:0]      stable_q, stable_d, stable_prev_q;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic [3:0]      press;

    state_t          state_q, state_d;
    logic [15:0]     pin_q, pin_d;
    logic [3:0]      cur_q, cur_d;
    logic [1:0]      idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    assign raw  = {bus.clk_slow, bus.btn_clear, bus.btn_enter, bus.btn_down, bus.btn_up};
    assign tick = sync2_q[4] & ~slow_prev_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if ((cnt_q[i] + 4'd1) == DB_LIMIT) begin
                        stable_d[i] = sync2_q[i];
                        cnt_d[i]    = 4'd0;
                    end else begin
                        cnt_d[i]    = cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_d[i] = 4'd0;
                end
            end
        end
    end

    // Rising edge of the debounced level lands one cycle after the qualifying tick.
    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|press) begin
                    state_d = ENTRY;
                    pin_d   = 16'h0000;
                    cur_d   = 4'd0;
                    idx_d   = 2'd0;
                end
            end
            ENTRY: begin
                if (press[3]) begin
                    pin_d = 16'h0000;
                    cur_d = 4'd0;
                    idx_d = 2'd0;
                end else if (press[2]) begin
                    case (idx_q)
                        2'd0:    pin_d[15:12] = cur_q;
                        2'd1:    pin_d[11:8]  = cur_q;
                        2'd2:    pin_d[7:4]   = cur_q;
                        default: pin_d[3:0]   = cur_q;
                    endcase
                    cur_d = 4'd0;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end
                end else if (press[0]) begin
                    cur_d = (cur_q == 4'd9) ? 4'd0 : cur_q + 4'd1;
                end else if (press[1]) begin
                    cur_d = (cur_q == 4'd0) ? 4'd9 : cur_q - 4'd1;
                end
            end
            DONE: begin
                if (press[3]) begin
                    state_d = ENTRY;
                    pin_d   = 16'h0000;
                    cur_d   = 4'd0;
                    idx_d   = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ENTRY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            slow_prev_q   <= 1'b0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            state_q       <= IDLE;
            pin_q         <= '0;
            cur_q         <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            slow_prev_q   <= sync2_q[4];
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            pin_q         <= pin_d;
            cur_q         <= cur_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
        end
    end

    assign bus.pin_out   = pin_q;
    assign bus.cur_digit = cur_q;
    assign bus.digit_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.pin_valid = valid_q;

endmodule

// File: tb/tb_pin_entry.sv
// Bench for pin_entry: table of button presses with expected outputs,
// routed through a scoreboard queue, plus bounce/glitch/reset sequences.
module tb_pin_entry;

    localparam int HOLD = 140;
    localparam logic [3:0] U = 4'b0001, D = 4'b0010, E = 4'b0100, C = 4'b1000;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] pin;
        logic [3:0]  cur;
        logic [1:0]  idx;
        logic        busy;
        int          vld;
    } vec_t;

    logic clk;
    logic rst_n;
    pin_entry_if bus ();

    pin_entry #(.DEBOUNCE_TICKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   vld_cnt  = 0;
    int   consec   = 0;
    logic vld_prev = 1'b0;
    vec_t tbl[$];
    vec_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.clk_slow = 1'b0;
        forever begin
            repeat (10) @(posedge clk);
            bus.clk_slow = ~bus.clk_slow;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev <= 1'b0;
        end else begin
            if (bus.pin_valid) begin
                vld_cnt <= vld_cnt + 1;
                if (vld_prev) consec <= consec + 1;
            end
            vld_prev <= bus.pin_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic set_btns(input logic [3:0] m);
        bus.btn_up    = m[0];
        bus.btn_down  = m[1];
        bus.btn_enter = m[2];
        bus.btn_clear = m[3];
    endtask

    task automatic compare_next(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_pin"},  {16'd0, bus.pin_out},  {16'd0, e.pin});
        check({tag, "_cur"},  {28'd0, bus.cur_digit}, {28'd0, e.cur});
        check({tag, "_idx"},  {30'd0, bus.digit_idx}, {30'd0, e.idx});
        check({tag, "_busy"}, {31'd0, bus.busy},      {31'd0, e.busy});
        check({tag, "_vld"},  vld_cnt,                e.vld);
    endtask

    task automatic press(input vec_t v, input string tag);
        exp_q.push_back(v);
        @(negedge clk);
        set_btns(v.mask);
        repeat (HOLD) @(negedge clk);
        set_btns(4'b0000);
        repeat (HOLD) @(negedge clk);
        compare_next(tag);
    endtask

    function automatic vec_t mk(input logic [3:0] m, input logic [15:0] p, input logic [3:0] c,
                                input logic [1:0] i, input logic b, input int v);
        vec_t r;
        r.mask = m; r.pin = p; r.cur = c; r.idx = i; r.busy = b; r.vld = v;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        set_btns(4'b0000);

        // Full entry to 3990, DONE hold, wrap, simultaneous clear+enter.
        tbl.push_back(mk(U, 16'h0000, 4'd0, 2'd0, 1'b1, 0));
        for (int k = 1; k <= 3; k++) tbl.push_back(mk(U, 16'h0000, 4'(k), 2'd0, 1'b1, 0));
        tbl.push_back(mk(E, 16'h3000, 4'd0, 2'd1, 1'b1, 0));
        for (int k = 1; k <= 9; k++) tbl.push_back(mk(U, 16'h3000, 4'(k), 2'd1, 1'b1, 0));
        tbl.push_back(mk(E, 16'h3900, 4'd0, 2'd2, 1'b1, 0));
        tbl.push_back(mk(D, 16'h3900, 4'd9, 2'd2, 1'b1, 0));
        tbl.push_back(mk(E, 16'h3990, 4'd0, 2'd3, 1'b1, 0));
        tbl.push_back(mk(E, 16'h3990, 4'd0, 2'd0, 1'b0, 1));
        tbl.push_back(mk(U, 16'h3990, 4'd0, 2'd0, 1'b0, 1));
        tbl.push_back(mk(E, 16'h3990, 4'd0, 2'd0, 1'b0, 1));
        tbl.push_back(mk(C, 16'h0000, 4'd0, 2'd0, 1'b1, 1));
        tbl.push_back(mk(D, 16'h0000, 4'd9, 2'd0, 1'b1, 1));
        tbl.push_back(mk(U, 16'h0000, 4'd0, 2'd0, 1'b1, 1));
        tbl.push_back(mk(U, 16'h0000, 4'd1, 2'd0, 1'b1, 1));
        tbl.push_back(mk(E, 16'h1000, 4'd0, 2'd1, 1'b1, 1));
        tbl.push_back(mk(U, 16'h1000, 4'd1, 2'd1, 1'b1, 1));
        tbl.push_back(mk(E, 16'h1100, 4'd0, 2'd2, 1'b1, 1));
        tbl.push_back(mk(C | E, 16'h0000, 4'd0, 2'd0, 1'b1, 1));
        tbl.push_back(mk(U, 16'h0000, 4'd1, 2'd0, 1'b1, 1));
        tbl.push_back(mk(E, 16'h1000, 4'd0, 2'd1, 1'b1, 1));
        tbl.push_back(mk(U, 16'h1000, 4'd1, 2'd1, 1'b1, 1));
        tbl.push_back(mk(U, 16'h1000, 4'd2, 2'd1, 1'b1, 1));
        tbl.push_back(mk(E, 16'h1200, 4'd0, 2'd2, 1'b1, 1));

        repeat (3) @(negedge clk);
        check("rst_pin",   {16'd0, bus.pin_out},   32'd0);
        check("rst_cur",   {28'd0, bus.cur_digit}, 32'd0);
        check("rst_idx",   {30'd0, bus.digit_idx}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},      32'd0);
        check("rst_valid", {31'd0, bus.pin_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an entry with two digits stored.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pin",  {16'd0, bus.pin_out},   32'd0);
        check("midrst_cur",  {28'd0, bus.cur_digit}, 32'd0);
        check("midrst_idx",  {30'd0, bus.digit_idx}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy},      32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        press(mk(D, 16'h0000, 4'd0, 2'd0, 1'b1, 1), "postrst");

        // Bouncing up button: toggles every 3 clk for 60 clk, then held.
        exp_q.push_back(mk(U, 16'h0000, 4'd1, 2'd0, 1'b1, 1));
        for (int k = 0; k < 20; k++) begin
            bus.btn_up = ~bus.btn_up;
            repeat (3) @(negedge clk);
        end
        check("bounce_early", {28'd0, bus.cur_digit}, 32'd0);
        bus.btn_up = 1'b1;
        repeat (HOLD) @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (HOLD) @(negedge clk);
        compare_next("bounce");

        // Short glitch on enter must be filtered out.
        exp_q.push_back(mk(E, 16'h0000, 4'd1, 2'd0, 1'b1, 1));
        bus.btn_enter = 1'b1;
        repeat (30) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (HOLD) @(negedge clk);
        compare_next("glitch");

        check("vld_consec", consec, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
